fp_class_sched: RTL and testbench

Round-robin scheduler that shares one pipelined floating-point classifier between `REQ_N` requesters. It sits between producer ports and the classification datapath built from `inf_chk`, `max_expo_chk` and `zero_mant_chk`. It arbitrates requests and registers operands and results. Each result is returned with the requester ID under valid/ready backpressure.

---
 rtl/fp_class_pkg.sv | 18 +
 rtl/fp_class_sched_if.sv | 31 +++
 rtl/inf_chk.sv | 23 ++
 rtl/max_expo_chk.sv | 9 +
 rtl/rr_arb.sv | 50 +++++
 rtl/zero_mant_chk.sv | 9 +
 rtl/fp_class_sched.sv | 132 +++++++++++++
 tb/tb_fp_class_sched.sv | 339 +++++++++++++++++++++++++++++++++
 8 files changed

// File: rtl/fp_class_pkg.sv
// Shared types and helpers for the floating-point class scheduler.
package fp_class_pkg;

    // One flag per class; at most one of inf/nan/zero is set for any operand.
    typedef struct packed {
        logic inf;
        logic inf_pos;
        logic inf_neg;
        logic nan;
        logic zero;
    } fp_class_t;

    // Total operand width from its field widths.
    function automatic int fp_w(input int sign_w, input int expo_w, input int mant_w);
        return sign_w + expo_w + mant_w;
    endfunction

endpackage

// File: rtl/fp_class_sched_if.sv
// Requester/response bundle between producers and the shared classifier.
interface fp_class_sched_if #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int REQ_N  = 4
);
    import fp_class_pkg::*;

    localparam int FP_W = fp_w(SIGN_W, EXPO_W, MANT_W);
    localparam int ID_W = $clog2(REQ_N);

    logic [REQ_N-1:0]           req_vld;
    logic [REQ_N-1:0]           req_rdy;
    logic [REQ_N-1:0][FP_W-1:0] req_data;
    logic                       rsp_vld;
    logic                       rsp_rdy;
    logic [ID_W-1:0]            rsp_id;
    fp_class_t                  rsp_class;

    modport master (
        output req_vld, req_data, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_id, rsp_class
    );

    modport slave (
        input  req_vld, req_data, rsp_rdy,
        output req_rdy, rsp_vld, rsp_id, rsp_class
    );

endinterface

// File: rtl/inf_chk.sv
// Infinity detection with sign split.
module inf_chk #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [SIGN_W-1:0] sign,
    input  logic [EXPO_W-1:0] expo,
    input  logic [MANT_W-1:0] mant,
    output logic              inf,
    output logic              inf_pos,
    output logic              inf_neg
);
    logic expo_max;
    logic mant_zero;

    max_expo_chk #(.EXPO_W(EXPO_W)) u_max_expo (.expo(expo), .is_max(expo_max));
    zero_mant_chk #(.MANT_W(MANT_W)) u_zero_mant (.mant(mant), .is_zero(mant_zero));

    assign inf     = expo_max && mant_zero;
    assign inf_pos = inf && !sign[SIGN_W-1];
    assign inf_neg = inf && sign[SIGN_W-1];
endmodule

// File: rtl/max_expo_chk.sv
// Flags an all-ones exponent field.
module max_expo_chk #(
    parameter int EXPO_W = 8
) (
    input  logic [EXPO_W-1:0] expo,
    output logic              is_max
);
    assign is_max = &expo;
endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps explicitly at REQ_N-1.
module rr_arb #(
    parameter int  REQ_N = 4,
    localparam int ID_W  = $clog2(REQ_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    input  logic             en,
    output logic [REQ_N-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;
    logic            found;
    int              idx;

    // First valid requester at or after ptr wins; explicit wrap handles non-power-of-two REQ_N.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = int'(ptr_reg);
        for (int k = 0; k < REQ_N; k++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
            idx = (idx == REQ_N - 1) ? 0 : idx + 1;
        end
    end

    // Pointer moves just past the winner only when the grant is actually taken.
    always_comb begin
        ptr_next = ptr_reg;
        if (en && found) begin
            ptr_next = (gnt_id == ID_W'(REQ_N - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/zero_mant_chk.sv
// Flags an all-zero mantissa field.
module zero_mant_chk #(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W-1:0] mant,
    output logic              is_zero
);
    assign is_zero = ~|mant;
endmodule

// File: rtl/fp_class_sched.sv
// Shares one two-stage FP classifier among REQ_N requesters with round-robin arbitration.
module fp_class_sched
    import fp_class_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int REQ_N  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_class_sched_if.slave bus
);
    localparam int FP_W = fp_w(SIGN_W, EXPO_W, MANT_W);
    localparam int ID_W = $clog2(REQ_N);

    logic [REQ_N-1:0]           gnt;
    logic [ID_W-1:0]            gnt_id;
    logic [REQ_N-1:0]           req_rdy;
    logic [REQ_N-1:0][FP_W-1:0] gnt_masked;
    logic [FP_W-1:0]            gnt_data;
    logic                       stall1;
    logic                       s0_open;
    logic                       accept;

    logic                       s0_vld_reg;
    logic [FP_W-1:0]            s0_data_reg;
    logic [ID_W-1:0]            s0_id_reg;
    logic                       rsp_vld_reg;
    logic [ID_W-1:0]            rsp_id_reg;
    fp_class_t                  rsp_class_reg;

    logic [SIGN_W-1:0]          s0_sign;
    logic [EXPO_W-1:0]          s0_expo;
    logic [MANT_W-1:0]          s0_mant;
    logic                       c_inf;
    logic                       c_inf_pos;
    logic                       c_inf_neg;
    logic                       expo_max;
    logic                       mant_zero;
    logic                       expo_zero;
    fp_class_t                  cls_next;

    // S0 can take a grant when empty or when its content moves on to S1 this edge.
    assign stall1  = rsp_vld_reg && !bus.rsp_rdy;
    assign s0_open = rst_n && (!s0_vld_reg || !stall1);
    assign req_rdy = s0_open ? gnt : '0;
    assign accept  = |req_rdy;

    rr_arb #(.REQ_N(REQ_N)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_vld),
        .en     (s0_open),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // One-hot grant selects the winning operand through an AND-OR mux.
    for (genvar gi = 0; gi < REQ_N; gi++) begin : g_mask
        assign gnt_masked[gi] = gnt[gi] ? bus.req_data[gi] : '0;
    end

    // OR-reduce the masked operands.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < REQ_N; i++) begin
            gnt_data = gnt_data | gnt_masked[i];
        end
    end

    // Operand stage: capture the granted operand and its requester ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld_reg  <= 1'b0;
            s0_data_reg <= '0;
            s0_id_reg   <= '0;
        end else if (s0_open) begin
            s0_vld_reg <= accept;
            if (accept) begin
                s0_data_reg <= gnt_data;
                s0_id_reg   <= gnt_id;
            end
        end
    end

    assign s0_sign   = s0_data_reg[FP_W-1 -: SIGN_W];
    assign s0_expo   = s0_data_reg[MANT_W +: EXPO_W];
    assign s0_mant   = s0_data_reg[MANT_W-1:0];
    assign expo_zero = (s0_expo == '0);

    inf_chk #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_inf_chk (
        .sign    (s0_sign),
        .expo    (s0_expo),
        .mant    (s0_mant),
        .inf     (c_inf),
        .inf_pos (c_inf_pos),
        .inf_neg (c_inf_neg)
    );
    max_expo_chk #(.EXPO_W(EXPO_W)) u_max_expo (.expo(s0_expo), .is_max(expo_max));
    zero_mant_chk #(.MANT_W(MANT_W)) u_zero_mant (.mant(s0_mant), .is_zero(mant_zero));

    // Classification of the S0 operand; zero ignores the sign.
    always_comb begin
        cls_next         = '0;
        cls_next.inf     = c_inf;
        cls_next.inf_pos = c_inf_pos;
        cls_next.inf_neg = c_inf_neg;
        cls_next.nan     = expo_max && !mant_zero;
        cls_next.zero    = expo_zero && mant_zero;
    end

    // Result stage: advances unless the consumer is stalling; payload only changes with real data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_reg   <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_class_reg <= '0;
        end else if (!stall1) begin
            rsp_vld_reg <= s0_vld_reg;
            if (s0_vld_reg) begin
                rsp_id_reg    <= s0_id_reg;
                rsp_class_reg <= cls_next;
            end
        end
    end

    assign bus.req_rdy   = req_rdy;
    assign bus.rsp_vld   = rsp_vld_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_class = rsp_class_reg;
endmodule

// File: tb/tb_fp_class_sched.sv
// Bench for fp_class_sched: per-requester sources, scoreboard of expected results, vector table.
`timescale 1ns/1ps
module tb_fp_class_sched;
    import fp_class_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_class_sched_if #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .REQ_N(4)) bus ();
    fp_class_sched_if #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .REQ_N(3)) bus3 ();

    fp_class_sched #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .REQ_N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    fp_class_sched #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .REQ_N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    typedef struct packed {
        logic [1:0] id;
        fp_class_t  cls;
    } sb_t;

    typedef struct {
        int          req;
        logic [31:0] data;
        fp_class_t   exp;
    } vec_t;

    sb_t         sb_q[$];
    int          grant_log[$];
    int          grant3_log[$];
    int          rsp_cyc[$];
    int          rsp_id_log[$];
    int          rsp3_ids[$];

    logic [31:0] src_data [N][DEPTH];
    fp_class_t   src_exp  [N][DEPTH];
    int          src_head [N];
    int          src_tail [N];
    logic [2:0]  vld3;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [1:0]  prev_id = '0;
    fp_class_t   prev_cls = '0;
    logic [N-1:0] last_rdy = '0;

    vec_t        vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Independent FP32 reference classification.
    function automatic fp_class_t model(input logic [31:0] x);
        fp_class_t   c;
        logic [7:0]  e;
        logic [22:0] m;
        c = '0;
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) begin
                c.inf = 1'b1;
                if (x[31]) c.inf_neg = 1'b1;
                else       c.inf_pos = 1'b1;
            end else begin
                c.nan = 1'b1;
            end
        end else if (e == 8'd0 && m == 23'd0) begin
            c.zero = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 4))
            0: x[30:23] = 8'hFF;
            1: begin x[30:23] = 8'hFF; x[22:0] = '0; end
            2: x[30:0] = '0;
            default: ;
        endcase
        return x;
    endfunction

    function automatic bit src_empty();
        bit e;
        e = 1'b1;
        for (int r = 0; r < N; r++) if (src_head[r] != src_tail[r]) e = 1'b0;
        return e;
    endfunction

    task automatic push_src(input int r, input logic [31:0] d, input fp_class_t e);
        src_data[r][src_tail[r] % DEPTH] = d;
        src_exp[r][src_tail[r] % DEPTH]  = e;
        src_tail[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (src_head[r] != src_tail[r]) begin
                bus.req_vld[r]  = 1'b1;
                bus.req_data[r] = src_data[r][src_head[r] % DEPTH];
            end else begin
                bus.req_vld[r]  = 1'b0;
                bus.req_data[r] = '0;
            end
        end
        bus3.req_vld = vld3;
    endtask

    // Sampled 1 ns before the rising edge: record accepts, compare responses.
    task automatic sample();
        sb_t e;
        last_rdy = bus.req_rdy;
        if (rst_n) begin
            check("rdy_onehot", 64'($onehot0(bus.req_rdy)), 64'(1));
            if (prev_stall) begin
                check("hold_vld", 64'(bus.rsp_vld), 64'(1));
                check("hold_id", 64'(bus.rsp_id), 64'(prev_id));
                check("hold_class", 64'(bus.rsp_class), 64'(prev_cls));
            end
            for (int r = 0; r < N; r++) begin
                if (bus.req_vld[r] && bus.req_rdy[r]) begin
                    e.id  = 2'(r);
                    e.cls = src_exp[r][src_head[r] % DEPTH];
                    sb_q.push_back(e);
                    grant_log.push_back(r);
                    $display("cyc %0d: accept req %0d data %08h", cyc, r, bus.req_data[r]);
                    src_head[r]++;
                    acc_cnt++;
                end
            end
            if (bus.rsp_vld && bus.rsp_rdy) begin
                $display("cyc %0d: response id %0d class %05b", cyc, bus.rsp_id, bus.rsp_class);
                if (sb_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL rsp_unexpected: got id %0d, expected no response", bus.rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    check("rsp_class", 64'(bus.rsp_class), 64'(e.cls));
                end
                rsp_cyc.push_back(cyc);
                rsp_id_log.push_back(int'(bus.rsp_id));
            end
            for (int r = 0; r < 3; r++) begin
                if (bus3.req_vld[r] && bus3.req_rdy[r]) grant3_log.push_back(r);
            end
            if (bus3.rsp_vld && bus3.rsp_rdy) rsp3_ids.push_back(int'(bus3.rsp_id));
        end
        prev_stall = rst_n && bus.rsp_vld && !bus.rsp_rdy;
        prev_id    = bus.rsp_id;
        prev_cls   = bus.rsp_class;
    endtask

    task automatic cycle();
        drive();
        #4;
        sample();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sb_q.size() != 0 || !src_empty()) && c < budget) begin
            cycle();
            c++;
        end
        check("drain_done", 64'(sb_q.size() == 0 && src_empty()), 64'(1));
        repeat (3) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 32'hFF800000, fp_class_t'(5'b10100)};
        vecs[1]  = '{1, 32'h7FC00000, fp_class_t'(5'b00010)};
        vecs[2]  = '{2, 32'h80000000, fp_class_t'(5'b00001)};
        vecs[3]  = '{3, 32'h3F800000, fp_class_t'(5'b00000)};
        vecs[4]  = '{0, 32'h00000000, fp_class_t'(5'b00001)};
        vecs[5]  = '{1, 32'h7F800001, fp_class_t'(5'b00010)};
        vecs[6]  = '{2, 32'hFFFFFFFF, fp_class_t'(5'b00010)};
        vecs[7]  = '{3, 32'h7F7FFFFF, fp_class_t'(5'b00000)};
        vecs[8]  = '{0, 32'h00000001, fp_class_t'(5'b00000)};
        vecs[9]  = '{1, 32'h80800000, fp_class_t'(5'b00000)};
        vecs[10] = '{2, 32'h7F800000, fp_class_t'(5'b11000)};

        for (int r = 0; r < N; r++) begin
            src_head[r] = 0;
            src_tail[r] = 0;
        end
        bus.req_vld   = '0;
        bus.req_data  = '0;
        bus.rsp_rdy   = 1'b1;
        bus3.req_vld  = '0;
        bus3.rsp_rdy  = 1'b1;
        bus3.req_data[0] = 32'h7F800000;
        bus3.req_data[1] = 32'h00000000;
        bus3.req_data[2] = 32'h7FC00000;
        vld3 = '0;
        rst_n = 1'b0;
        @(negedge clk);

        // Reset: requester 1 valid, nothing may be accepted, outputs cleared.
        push_src(1, 32'h3F800000, fp_class_t'(5'b00000));
        cycle();
        cycle();
        check("reset_req_rdy", 64'(last_rdy), 64'(0));
        check("reset_rsp_vld", 64'(bus.rsp_vld), 64'(0));
        check("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("reset_rsp_class", 64'(bus.rsp_class), 64'(0));
        rst_n = 1'b1;
        drain(50);

        // Single requester 2 sending +inf: response visible two edges after the request cycle.
        push_src(2, 32'h7F800000, fp_class_t'(5'b11000));
        cycle();
        check("t1_accept", 64'(last_rdy), 64'(4'b0100));
        check("t1_rsp_vld_early", 64'(bus.rsp_vld), 64'(0));
        cycle();
        check("t1_rsp_vld", 64'(bus.rsp_vld), 64'(1));
        check("t1_rsp_id", 64'(bus.rsp_id), 64'(2));
        check("t1_rsp_class", 64'(bus.rsp_class), 64'(5'b11000));
        drain(50);

        // Vector table, first four together from reset: ids 0..3 on consecutive cycles.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        grant_log.delete();
        rsp_cyc.delete();
        rsp_id_log.delete();
        for (int v = 0; v < 4; v++) push_src(vecs[v].req, vecs[v].data, vecs[v].exp);
        drain(50);
        check("t2_n_rsp", 64'(rsp_id_log.size()), 64'(4));
        for (int k = 0; k < 4 && k < rsp_id_log.size(); k++) begin
            check("t2_rsp_order", 64'(rsp_id_log[k]), 64'(k));
            check("t2_rsp_cycle", 64'(rsp_cyc[k]), 64'(rsp_cyc[0] + k));
        end
        for (int v = 4; v < 11; v++) push_src(vecs[v].req, vecs[v].data, vecs[v].exp);
        drain(80);

        // Backpressure: 5 stalled cycles with all requesting, exactly two accepts.
        bus.rsp_rdy = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 3; j++) begin
                logic [31:0] d;
                d = rand_fp();
                push_src(r, d, model(d));
            end
        end
        begin
            int acc0;
            acc0 = acc_cnt;
            for (int k = 0; k < 5; k++) begin
                cycle();
                if (k >= 2) check("t3_req_rdy_low", 64'(last_rdy), 64'(0));
            end
            check("t3_accepts", 64'(acc_cnt - acc0), 64'(2));
        end
        bus.rsp_rdy = 1'b1;
        drain(100);

        // Pointer at 3 with requesters 1 and 3 valid: 3, 1, 3, 1.
        push_src(2, 32'h40000000, fp_class_t'(5'b00000));
        drain(50);
        grant_log.delete();
        push_src(1, 32'hFF800000, fp_class_t'(5'b10100));
        push_src(1, 32'h00000000, fp_class_t'(5'b00001));
        push_src(3, 32'h7FFFFFFF, fp_class_t'(5'b00010));
        push_src(3, 32'h7F800000, fp_class_t'(5'b11000));
        drain(50);
        check("t4_n_grants", 64'(grant_log.size()), 64'(4));
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            check("t4_grant_order", 64'(grant_log[k]), 64'((k % 2 == 0) ? 3 : 1));
        end

        // Three-requester instance, all valid for seven grants: 0,1,2,0,1,2,0.
        grant3_log.delete();
        rsp3_ids.delete();
        vld3 = 3'b111;
        repeat (7) cycle();
        vld3 = 3'b000;
        repeat (3) cycle();
        check("t5_n_grants", 64'(grant3_log.size()), 64'(7));
        for (int k = 0; k < 7 && k < grant3_log.size(); k++) begin
            check("t5_grant_order", 64'(grant3_log[k]), 64'(k % 3));
        end
        check("t5_n_rsp", 64'(rsp3_ids.size()), 64'(7));
        for (int k = 0; k < 7 && k < rsp3_ids.size(); k++) begin
            check("t5_rsp_id", 64'(rsp3_ids[k]), 64'(k % 3));
        end

        // Reset with both stages full: no stale response, first grant to requester 0.
        bus.rsp_rdy = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 2; j++) begin
                logic [31:0] d;
                d = rand_fp();
                push_src(r, d, model(d));
            end
        end
        cycle();
        cycle();
        check("t6_full_rsp_vld", 64'(bus.rsp_vld), 64'(1));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("t6_rsp_vld_cleared", 64'(bus.rsp_vld), 64'(0));
        check("t6_rsp_id_cleared", 64'(bus.rsp_id), 64'(0));
        check("t6_rsp_class_cleared", 64'(bus.rsp_class), 64'(0));
        sb_q.delete();
        grant_log.delete();
        bus.rsp_rdy = 1'b1;
        drain(100);
        check("t6_first_grant_present", 64'(grant_log.size() > 0), 64'(1));
        if (grant_log.size() > 0) check("t6_first_grant", 64'(grant_log[0]), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
